// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding,
// bus-level ACK/NACK values and the default target address.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_ADDR_ACK  = 3'd2,
    S_RX_BYTE   = 3'd3,
    S_RX_ACK    = 3'd4,
    S_TX_BYTE   = 3'd5,
    S_TX_ACK    = 3'd6,
    S_WAIT_STOP = 3'd7
  } state_t;

  localparam logic       ACK          = 1'b0;
  localparam logic       NACK         = 1'b1;
  localparam logic       RW_READ      = 1'b1;
  localparam logic [6:0] DEFAULT_ADDR = 7'h50;

endpackage

// File: rtl/i2c_target_if.sv
// Bus and register-side signals of the I2C target. The master modport is the
// side that drives SCL/SDA and supplies read data; the slave modport is the target.
interface i2c_target_if;

  logic        i_scl;
  logic        i_sda;
  logic        o_sda_en;
  logic [15:0] o_data;
  logic        o_valid;
  logic [15:0] i_tx_data;
  logic        o_busy;

  modport master (
    output i_scl, i_sda, i_tx_data,
    input  o_sda_en, o_data, o_valid, o_busy
  );

  modport slave (
    input  i_scl, i_sda, i_tx_data,
    output o_sda_en, o_data, o_valid, o_busy
  );

endinterface

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for an asynchronous bus line, followed by a register
// stage that presents the level together with aligned rise/fall pulses.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level_r,
  output logic rise_r,
  output logic fall_r
);

  logic meta_r;
  logic sync_r;

  // Synchronize, then compare against the previous level; idle bus reads high.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r  <= 1'b1;
      sync_r  <= 1'b1;
      level_r <= 1'b1;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      meta_r  <= din;
      sync_r  <= meta_r;
      level_r <= sync_r;
      rise_r  <= sync_r & ~level_r;
      fall_r  <= ~sync_r & level_r;
    end
  end

endmodule

// File: rtl/i2c_target.sv
// I2C target: matches a 7-bit address, receives a 16-bit word on writes and
// returns a 16-bit word on reads, with START/STOP honoured in every state.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR = DEFAULT_ADDR
) (
  input logic          i_clk,
  input logic          i_rst,
  i2c_target_if.slave  bus
);

  logic       scl_lvl_s, scl_rise_s, scl_fall_s;
  logic       sda_lvl_s, sda_rise_s, sda_fall_s;
  logic       start_s, stop_s;

  state_t      state_r;
  logic [2:0]  bit_cnt_r;
  logic        byte_idx_r;
  logic        phase_r;
  logic        rw_r;
  logic [7:0]  shift_r;
  logic [7:0]  byte1_r;
  logic        sda_en_r;
  logic [15:0] data_r;
  logic        valid_r;
  logic        busy_r;

  i2c_sync_edge u_scl_sync (
    .clk(i_clk), .rst(i_rst), .din(bus.i_scl),
    .level_r(scl_lvl_s), .rise_r(scl_rise_s), .fall_r(scl_fall_s)
  );

  i2c_sync_edge u_sda_sync (
    .clk(i_clk), .rst(i_rst), .din(bus.i_sda),
    .level_r(sda_lvl_s), .rise_r(sda_rise_s), .fall_r(sda_fall_s)
  );

  assign start_s = sda_fall_s & scl_lvl_s;
  assign stop_s  = sda_rise_s & scl_lvl_s;

  // Protocol FSM; phase_r splits each ACK slot into "drive" and "release" falls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= S_IDLE;
      bit_cnt_r  <= 3'd0;
      byte_idx_r <= 1'b0;
      phase_r    <= 1'b0;
      rw_r       <= 1'b0;
      shift_r    <= 8'h00;
      byte1_r    <= 8'h00;
      sda_en_r   <= 1'b0;
      data_r     <= 16'h0000;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (stop_s) begin
        state_r    <= S_IDLE;
        sda_en_r   <= 1'b0;
        busy_r     <= 1'b0;
        bit_cnt_r  <= 3'd0;
        byte_idx_r <= 1'b0;
        phase_r    <= 1'b0;
      end else if (start_s) begin
        state_r    <= S_ADDR;
        sda_en_r   <= 1'b0;
        bit_cnt_r  <= 3'd0;
        byte_idx_r <= 1'b0;
        phase_r    <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE: begin
            sda_en_r <= 1'b0;
          end
          S_ADDR: begin
            if (scl_rise_s) begin
              shift_r   <= {shift_r[6:0], sda_lvl_s};
              bit_cnt_r <= bit_cnt_r + 3'd1;
              // shift_r[6:0] already holds the 7 address bits; sda is R/W.
              if (bit_cnt_r == 3'd7) begin
                if ((shift_r[6:0] == ADDR) && (shift_r[6:0] != 7'h00)) begin
                  state_r <= S_ADDR_ACK;
                  busy_r  <= 1'b1;
                  rw_r    <= sda_lvl_s;
                  phase_r <= 1'b0;
                end else begin
                  state_r <= S_WAIT_STOP;
                  busy_r  <= 1'b0;
                end
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall_s) begin
              if (!phase_r) begin
                sda_en_r <= 1'b1;
                phase_r  <= 1'b1;
              end else begin
                phase_r    <= 1'b0;
                bit_cnt_r  <= 3'd0;
                byte_idx_r <= 1'b0;
                if (rw_r == RW_READ) begin
                  shift_r  <= bus.i_tx_data[15:8];
                  byte1_r  <= bus.i_tx_data[7:0];
                  sda_en_r <= ~bus.i_tx_data[15];
                  state_r  <= S_TX_BYTE;
                end else begin
                  sda_en_r <= 1'b0;
                  state_r  <= S_RX_BYTE;
                end
              end
            end
          end
          S_RX_BYTE: begin
            if (scl_rise_s) begin
              shift_r   <= {shift_r[6:0], sda_lvl_s};
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                state_r <= S_RX_ACK;
                phase_r <= 1'b0;
              end
            end
          end
          S_RX_ACK: begin
            if (scl_fall_s) begin
              if (!phase_r) begin
                sda_en_r <= 1'b1;
                phase_r  <= 1'b1;
              end else begin
                sda_en_r <= 1'b0;
                phase_r  <= 1'b0;
                if (!byte_idx_r) begin
                  byte1_r    <= shift_r;
                  byte_idx_r <= 1'b1;
                  bit_cnt_r  <= 3'd0;
                  state_r    <= S_RX_BYTE;
                end else begin
                  data_r  <= {byte1_r, shift_r};
                  valid_r <= 1'b1;
                  state_r <= S_WAIT_STOP;
                end
              end
            end
          end
          S_TX_BYTE: begin
            if (scl_fall_s) begin
              if (bit_cnt_r == 3'd7) begin
                sda_en_r  <= 1'b0;
                bit_cnt_r <= 3'd0;
                phase_r   <= 1'b0;
                state_r   <= S_TX_ACK;
              end else begin
                shift_r   <= {shift_r[6:0], 1'b0};
                sda_en_r  <= ~shift_r[6];
                bit_cnt_r <= bit_cnt_r + 3'd1;
              end
            end
          end
          S_TX_ACK: begin
            if (scl_rise_s && !phase_r) begin
              if ((sda_lvl_s == NACK) || byte_idx_r) begin
                state_r <= S_WAIT_STOP;
              end else begin
                phase_r <= 1'b1;
              end
            end else if (scl_fall_s && phase_r) begin
              shift_r    <= byte1_r;
              sda_en_r   <= ~byte1_r[7];
              byte_idx_r <= 1'b1;
              bit_cnt_r  <= 3'd0;
              phase_r    <= 1'b0;
              state_r    <= S_TX_BYTE;
            end else begin
              sda_en_r <= 1'b0;
            end
          end
          S_WAIT_STOP: begin
            sda_en_r <= 1'b0;
          end
          default: begin
            state_r  <= S_IDLE;
            sda_en_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_sda_en = sda_en_r;
  assign bus.o_data   = data_r;
  assign bus.o_valid  = valid_r;
  assign bus.o_busy   = busy_r;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: an open-drain initiator model drives SCL/SDA
// (20-cycle SCL period) and checks ACKs, read data and register-side outputs.
module tb_i2c_target;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  int chk_cnt = 0;
  int fail_cnt = 0;
  int valid_cnt = 0;
  int en_cnt = 0;
  int busy_cnt = 0;

  i2c_target_if bus_if ();

  assign bus_if.i_scl = scl_m;
  assign bus_if.i_sda = sda_m & ~bus_if.o_sda_en;

  i2c_target #(.ADDR(7'h50)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus_if.slave)
  );

  always #5 clk = ~clk;

  // Event counters for the register-side outputs, sampled on the inactive edge.
  always @(negedge clk) begin
    if (bus_if.o_valid)  valid_cnt++;
    if (bus_if.o_sda_en) en_cnt++;
    if (bus_if.o_busy)   busy_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period: data set mid-low, bus sampled mid-high.
  task automatic clock_bit(input logic b, output logic seen, output logic en);
    wait_cyc(2);
    sda_m = b;
    wait_cyc(8);
    scl_m = 1'b1;
    wait_cyc(5);
    seen = bus_if.i_sda;
    en   = bus_if.o_sda_en;
    wait_cyc(5);
    scl_m = 1'b0;
  endtask

  task automatic start_cond();
    wait_cyc(4);
    sda_m = 1'b1;
    wait_cyc(4);
    scl_m = 1'b1;
    wait_cyc(10);
    sda_m = 1'b0;
    wait_cyc(10);
    scl_m = 1'b0;
  endtask

  task automatic stop_cond();
    wait_cyc(4);
    sda_m = 1'b0;
    wait_cyc(4);
    scl_m = 1'b1;
    wait_cyc(10);
    sda_m = 1'b1;
    wait_cyc(10);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s, e;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s, e);
    clock_bit(1'b1, ack, e);
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] d, output logic en_ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, d[i], s);
    end
    clock_bit(m_ack, s, en_ack);
  endtask

  initial begin
    logic       ack, en, s;
    logic [7:0] rd;
    int         v0, e0, b0;

    bus_if.i_tx_data = 16'h0000;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(1);
    check("rst_sda_en", 16'(bus_if.o_sda_en), 16'h0000);
    check("rst_data",   bus_if.o_data,         16'h0000);
    check("rst_valid",  16'(bus_if.o_valid),   16'h0000);
    check("rst_busy",   16'(bus_if.o_busy),    16'h0000);
    wait_cyc(10);

    // Write 0x1234
    v0 = valid_cnt;
    start_cond();
    send_byte(8'hA0, ack); check("wr_addr_ack", 16'(ack), 16'h0000);
    check("wr_busy", 16'(bus_if.o_busy), 16'h0001);
    send_byte(8'h12, ack); check("wr_b1_ack", 16'(ack), 16'h0000);
    send_byte(8'h34, ack); check("wr_b2_ack", 16'(ack), 16'h0000);
    stop_cond();
    check("wr_data",  bus_if.o_data, 16'h1234);
    check("wr_valid", 16'(valid_cnt - v0), 16'h0001);
    check("wr_busy_after_stop", 16'(bus_if.o_busy), 16'h0000);

    // Read 0xBEEF: ACK byte 1, NACK byte 2
    bus_if.i_tx_data = 16'hBEEF;
    v0 = valid_cnt;
    start_cond();
    send_byte(8'hA1, ack); check("rd_addr_ack", 16'(ack), 16'h0000);
    read_byte(1'b0, rd, en); check("rd_byte1", 16'(rd), 16'h00BE);
    check("rd_ack1_released", 16'(en), 16'h0000);
    read_byte(1'b1, rd, en); check("rd_byte2", 16'(rd), 16'h00EF);
    check("rd_ack2_released", 16'(en), 16'h0000);
    stop_cond();
    check("rd_no_valid", 16'(valid_cnt - v0), 16'h0000);
    check("rd_data_kept", bus_if.o_data, 16'h1234);

    // Address mismatch
    e0 = en_cnt; b0 = busy_cnt;
    start_cond();
    send_byte(8'hA2, ack); check("mm_addr_nack", 16'(ack), 16'h0001);
    send_byte(8'h55, ack); check("mm_data_nack", 16'(ack), 16'h0001);
    stop_cond();
    check("mm_sda_en_never", 16'(en_cnt - e0), 16'h0000);
    check("mm_busy_never",   16'(busy_cnt - b0), 16'h0000);
    check("mm_data_kept",    bus_if.o_data, 16'h1234);

    // Abort mid byte 2, then a full write of 0x0001
    v0 = valid_cnt;
    start_cond();
    send_byte(8'hA0, ack); check("ab_addr_ack", 16'(ack), 16'h0000);
    send_byte(8'h12, ack); check("ab_b1_ack", 16'(ack), 16'h0000);
    for (int i = 0; i < 4; i++) clock_bit(1'b1, s, en);
    stop_cond();
    check("ab_no_valid", 16'(valid_cnt - v0), 16'h0000);
    check("ab_data_kept", bus_if.o_data, 16'h1234);
    start_cond();
    send_byte(8'hA0, ack); check("ab2_addr_ack", 16'(ack), 16'h0000);
    send_byte(8'h00, ack); check("ab2_b1_ack", 16'(ack), 16'h0000);
    send_byte(8'h01, ack); check("ab2_b2_ack", 16'(ack), 16'h0000);
    wait_cyc(6);
    check("ab2_data", bus_if.o_data, 16'h0001);
    check("ab2_valid", 16'(valid_cnt - v0), 16'h0001);
    stop_cond();

    // Repeated start into a read, then reset while the address ACK is driven
    bus_if.i_tx_data = 16'h5A3C;
    start_cond();
    send_byte(8'hA0, ack); check("rs_addr_ack", 16'(ack), 16'h0000);
    send_byte(8'h12, ack); check("rs_b1_ack", 16'(ack), 16'h0000);
    start_cond();
    for (int i = 7; i >= 0; i--) begin
      rd = 8'hA1;
      clock_bit(rd[i], s, en);
    end
    wait_cyc(2);
    sda_m = 1'b1;
    wait_cyc(8);
    scl_m = 1'b1;
    wait_cyc(3);
    check("rs_ack_driven", 16'(bus_if.o_sda_en), 16'h0001);
    check("rs_busy", 16'(bus_if.o_busy), 16'h0001);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    check("rs_rst_sda_en", 16'(bus_if.o_sda_en), 16'h0000);
    check("rs_rst_data",   bus_if.o_data,         16'h0000);
    check("rs_rst_valid",  16'(bus_if.o_valid),   16'h0000);
    check("rs_rst_busy",   16'(bus_if.o_busy),    16'h0000);
    wait_cyc(5);
    scl_m = 1'b0;
    stop_cond();

    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
